// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, word type and sequencer state encoding
`timescale 1ns/1ps
package rf_pkg;

  localparam int N      = 8;
  localparam int DATA_W = 4;
  localparam int IDX_W  = $clog2(N);
  localparam int CNT_W  = $clog2(N * (N - 1) / 2 + 1);

  typedef logic [DATA_W-1:0] rf_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SWP  = 2'd2,
    DONE = 2'd3
  } sort_state_t;

endpackage

// File: rtl/order_cmp.sv
// rtl/order_cmp.sv - unsigned adjacent-pair order check for the bubble sort
`timescale 1ns/1ps
module order_cmp
  import rf_pkg::*;
(
  input  rf_word_t a,
  input  rf_word_t b,
  input  logic     desc,
  output logic     out_of_order
);

  // Equal values are never reported out of order, so the sort stays stable
  // and an all-equal file finishes without a single swap.
  assign out_of_order = desc ? (a < b) : (a > b);

endmodule

// File: rtl/rf_sort_ctrl.sv
// rtl/rf_sort_ctrl.sv - in-place bubble sort sequencer for the swap register file
`timescale 1ns/1ps
module rf_sort_ctrl #(
  parameter int N      = rf_pkg::N,
  parameter int IDX_W  = $clog2(N),
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int CNT_W  = $clog2(N * (N - 1) / 2 + 1)
) (
  input  logic                clk,
  input  logic                init_n,
  input  logic                start,
  input  logic                descending,
  input  logic [N*DATA_W-1:0] r,
  output logic                swap,
  output logic [IDX_W-1:0]    x,
  output logic [IDX_W-1:0]    y,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    swap_count
);

  rf_pkg::sort_state_t state;
  logic [IDX_W-1:0]    i;
  logic [IDX_W-1:0]    pass;
  logic                dirty;
  logic                desc_q;

  logic [DATA_W-1:0]   word [N];
  logic [IDX_W-1:0]    i_next;
  logic [IDX_W-1:0]    last_i;
  logic                pass_end;
  logic                final_pass;
  logic                out_of_order;

  // Advance decision shared by CMP (in-order) and SWP
  logic                dirty_eff;
  logic                adv_done;
  logic [IDX_W-1:0]    adv_i;
  logic [IDX_W-1:0]    adv_pass;
  logic                adv_dirty;

  // Unpack the flat register-file bus into indexable words
  always_comb begin
    for (int k = 0; k < N; k++) begin
      word[k] = r[k*DATA_W +: DATA_W];
    end
  end

  assign i_next     = i + 1'b1;
  // Each pass shrinks by one: the largest/smallest value has bubbled to the end.
  assign last_i     = IDX_W'(N - 2) - pass;
  assign pass_end   = (i >= last_i);
  assign final_pass = (pass == IDX_W'(N - 2));

  order_cmp u_order_cmp (
    .a            (word[i]),
    .b            (word[i_next]),
    .desc         (desc_q),
    .out_of_order (out_of_order)
  );

  // Next index/pass/dirty when leaving CMP (in order) or SWP
  always_comb begin
    dirty_eff = dirty | (state == rf_pkg::SWP);
    adv_done  = pass_end && (!dirty_eff || final_pass);
    adv_i     = pass_end ? '0 : i_next;
    adv_pass  = (pass_end && !adv_done) ? pass + 1'b1 : pass;
    adv_dirty = pass_end ? 1'b0 : dirty_eff;
  end

  // Sequencer FSM with registered command and handshake outputs
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state      <= rf_pkg::IDLE;
      i          <= '0;
      pass       <= '0;
      dirty      <= 1'b0;
      desc_q     <= 1'b0;
      swap       <= 1'b0;
      x          <= '0;
      y          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      swap_count <= '0;
    end else begin
      swap <= 1'b0;
      x    <= '0;
      y    <= '0;
      done <= 1'b0;
      case (state)
        rf_pkg::IDLE: begin
          if (start) begin
            state      <= rf_pkg::CMP;
            i          <= '0;
            pass       <= '0;
            dirty      <= 1'b0;
            swap_count <= '0;
            desc_q     <= descending;
            busy       <= 1'b1;
          end
        end
        rf_pkg::CMP: begin
          if (out_of_order) begin
            // Swap takes its own cycle so the next compare sees the file updated.
            state <= rf_pkg::SWP;
            swap  <= 1'b1;
            x     <= i;
            y     <= i_next;
          end else begin
            state <= adv_done ? rf_pkg::DONE : rf_pkg::CMP;
            i     <= adv_i;
            pass  <= adv_pass;
            dirty <= adv_dirty;
            done  <= adv_done;
          end
        end
        rf_pkg::SWP: begin
          swap_count <= swap_count + 1'b1;
          state      <= adv_done ? rf_pkg::DONE : rf_pkg::CMP;
          i          <= adv_i;
          pass       <= adv_pass;
          dirty      <= adv_dirty;
          done       <= adv_done;
        end
        rf_pkg::DONE: begin
          state <= rf_pkg::IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= rf_pkg::IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rf_sort_ctrl.md
# rf_sort_ctrl

Sequencer that sits directly upstream of the 8-entry swap register file. It drives the file's `swap`/`x`/`y` command port and reads back its `r` array, sorting the contents in place with an adjacent-pair bubble sort. It exits early on a swap-free pass and reports completion with a start/busy/done handshake plus a swap count.

## Interface
Parameters:
- `N`, 8: register-file entries.
- `IDX_W`, `$clog2(N)` = 3: index width.
- `DATA_W`, 4: entry width.
- `CNT_W`, `$clog2(N*(N-1)/2+1)` = 5: swap counter width.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `init_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a sort; sampled in IDLE only.
- `descending` in 1: order select, 0 = ascending, 1 = descending. Latched at start.
- `r` in `N`×`DATA_W`: live register-file contents, `r[N-1:0]`.
- `swap` out 1: register-file swap strobe. Never high for more than one consecutive cycle.
- `x` out `IDX_W`: lower swap index.
- `y` out `IDX_W`: upper swap index. Always `x+1` while `swap` is high.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `swap_count` out `CNT_W`: swaps issued by the current or last sort. Held until the next start.

## Operation
- States: IDLE, CMP, SWP, DONE.
- **IDLE**
  - `start`=1 → CMP, with `i`=0, `pass`=0, `dirty`=0, `swap_count`=0.
  - Latch `descending` into `desc_q`.
- **CMP**
  - Compare `r[i]` with `r[i+1]`, unsigned.
  - Out of order when `r[i] > r[i+1]` (ascending) or `r[i] < r[i+1]` (descending). Equal values are never swapped.
  - Out of order → SWP.
  - In order → advance.
- **SWP**
  - `swap`=1, `x`=`i`, `y`=`i+1` for exactly this cycle.
  - `swap_count`+1 and `dirty`=1, both registered at the end of the cycle.
  - Then advance.
- **Advance**
  - If `i` < `N-2-pass`: `i`+1 → CMP.
  - Otherwise the pass is complete:
    - `dirty`=0, or `pass` = `N-2` → DONE.
    - Else `pass`+1, `i`=0, `dirty`=0 → CMP.
- **DONE**
  - `done`=1 for one cycle → IDLE.
- `start` is ignored in CMP, SWP and DONE. No queuing.
- `x` and `y` are don't-care when `swap`=0 and are driven to 0.

## Timing
- Reset: `init_n` low at a rising edge forces, on that edge, IDLE with `swap`=0, `x`=0, `y`=0, `busy`=0, `done`=0, `swap_count`=0 and all internal counters at 0.
- Reset mid-operation aborts immediately. No further `swap` is issued.
- The register file is reset by the same source at top level (`init` = ~`init_n`), so after reset `r[k]`=k.
- Outputs:
  - `swap`, `x`, `y`, `busy`, `done` decode from registered state only; no combinational path from `r` or `start`.
  - `swap_count` is a register.
- Swap visibility: the register file updates at the edge ending SWP. The following CMP sees the swapped values. This is why CMP and SWP never share a cycle.
- Cost per comparison: 1 cycle, plus 1 cycle per swap.
- Latency, with start sampled at edge 0:
  - `done` is high during cycle C+S+1, where C = comparisons made and S = swaps.
  - Worst case for N=8: 28 comparisons + 28 swaps → `done` in cycle 57.
- `busy` rises in the cycle after the start edge. It falls in the cycle after `done`.
- `swap_count` ≤ 28 and cannot wrap.

## Structure
- Package `rf_pkg` holds:
  - `N`, `DATA_W`, `IDX_W`.
  - `rf_word_t` (`logic [DATA_W-1:0]`).
  - `sort_state_t` enum {IDLE, CMP, SWP, DONE}.
- The register file imports the same package for its widths.
- Sub-module `order_cmp`: combinational compare of two `rf_word_t` values plus `desc`, producing `out_of_order`.
- The FSM, counters and output registers stay in `rf_sort_ctrl`.

## Test plan
- Reset, then `start` ascending on identity `r`=0..7 → 7 CMP cycles, no `swap`, `done` in cycle 8, `swap_count`=0.
- Reset, then `start` descending on identity → 28 single-cycle `swap` pulses, first `x`=0,`y`=1. `r` ends 7..0, `done` in cycle 57, `swap_count`=28.
- Preload `r`={0,1,2,3,4,5,7,6}, ascending → one swap `x`=6,`y`=7 in pass 0. Pass 1 is clean → exits early. `swap_count`=1, `done` in cycle 7+1+6+1=15.
- All entries equal to 5, both orders → no `swap`, `swap_count`=0.
- `start` held high throughout a sort, with `descending` toggled mid-sort → the sort is unaffected. A second sort begins only from IDLE after `done`.
- `init_n` low during cycle 10 of a descending sort → next cycle IDLE, `busy`=0, `swap`=0, `swap_count`=0. No `swap` is issued afterwards.
